// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-add-3, "double dabble").
// It converts an unsigned BIN_W-bit value over BIN_W+1 cycles.
// It holds four stable BCD digits for a 4-digit seven-segment driver.
// Values above 9999 saturate to 9,9,9,9 and set ovf.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   reset     in   synchronous, active-high reset
//   bin_in    in   [BIN_W-1:0] unsigned value, sampled on accept
//   in_valid  in   request: bin_in is valid
//   in_ready  out  converter idle and able to accept (state == IDLE)
//   busy      out  conversion in progress (state != IDLE)
//   done      out  one-cycle pulse: dig*/ovf were just updated
//   ovf       out  last result saturated (value > 9999)
//   dig3..0   out  [3:0] BCD digits, dig3 = thousands (leftmost)
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0
);
    // Five BCD nibbles are enough for any 16-bit input (max 65535).
    localparam int SCR_W = 20;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        dig_q, dig_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    // Add-3 correction.
    // Every nibble is judged on its pre-shift value, all in parallel.
    // Any nibble >= 5 would reach >= 10 after the doubling shift, so it gets +3 first.
    generate
        for (genvar gi = 0; gi < SCR_W / 4; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                          ? scratch_q[gi*4 +: 4] + 4'd3
                                          : scratch_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        dig_d     = dig_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The MSB of the binary shift register enters scratch bit 0.
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A non-zero ten-thousands nibble means the display cannot show it.
                if (scratch_q[19:16] != 4'd0) begin
                    dig_d = 16'h9999;
                    ovf_d = 1'b1;
                end else begin
                    dig_d = scratch_q[15:0];
                    ovf_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign dig3     = dig_q[15:12];
    assign dig2     = dig_q[11:8];
    assign dig1     = dig_q[7:4];
    assign dig0     = dig_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq (BIN_W = 16).
// Every result is compared against a decimal reference model.
// The model computes v/1000%10 etc. and saturates above 9999.
// The bench also checks latency, in_ready/busy, the done pulse and output hold.
// It covers back-to-back accepts, overflow, and reset in mid-conversion.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;
    localparam int BIN_W   = 16;
    localparam int LATENCY = BIN_W + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [BIN_W-1:0] bin_in;
    logic             in_valid;
    logic             in_ready, busy, done, ovf;
    logic [3:0]       dig3, dig2, dig1, dig0;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bin_in   (bin_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1),
        .dig0     (dig0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result, returned as {ovf, d3, d2, d1, d0}.
    function automatic logic [16:0] ref_bcd(input int v);
        logic [16:0] r;
        if (v > 9999) begin
            r = {1'b1, 16'h9999};
        end else begin
            r = {1'b0, 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        end
        return r;
    endfunction

    function automatic logic [16:0] dut_res();
        return {ovf, dig3, dig2, dig1, dig0};
    endfunction

    // Called at the negedge just after the accept edge.
    // It waits for done with a cycle bound and checks that in_ready stays low and the outputs hold.
    // With jitter set, it wiggles bin_in/in_valid on every cycle of the conversion.
    // n ends as the number of cycles from the accept cycle to the done cycle.
    task automatic wait_done(input bit jitter, input logic [16:0] prev, output int n);
        n = 1;
        while (done !== 1'b1 && n < LATENCY + 10) begin
            check("ready_low_busy", {31'd0, in_ready}, 32'd0);
            check("output_hold", {15'd0, dut_res()}, {15'd0, prev});
            if (jitter) begin
                in_valid = 1'($urandom);
                bin_in   = BIN_W'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 32'd0, 32'd1);
        end
    endtask

    // Runs one full transaction: accept v, wait for done, then check the result and the pulse width.
    task automatic convert(input int v, input bit jitter);
        int n;
        logic [16:0] prev;
        logic [16:0] exp;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before", {31'd0, in_ready}, 32'd1);
        prev     = dut_res();
        exp      = ref_bcd(v);
        bin_in   = BIN_W'(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(jitter, prev, n);
        in_valid = 1'b0;
        check("latency", n, LATENCY);
        check("result", {15'd0, dut_res()}, {15'd0, exp});
        check("ready_on_done", {31'd0, in_ready}, 32'd1);
        $display("conv v=%0d -> dig=%h ovf=%0b (expected %h ovf=%0b) cycles=%0d",
                 v, dut_res() & 17'hFFFF, ovf, exp[15:0], exp[16], n);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int done_cnt;
        int bounds[14] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 10001, 65534, 65535};

        // Reset for two cycles; in_valid must be ignored while reset is high.
        reset    = 1'b1;
        in_valid = 1'b1;
        bin_in   = 16'd777;
        repeat (2) @(negedge clk);
        check("reset_outputs", {15'd0, dut_res()}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);

        // 1) single conversion
        convert(1234, 1'b0);

        // 2) back-to-back with in_valid held: the second accept lands on the done cycle
        bin_in   = 16'd0;
        in_valid = 1'b1;
        @(negedge clk);
        wait_done(1'b0, {1'b0, 16'h1234}, n);
        check("b2b_latency0", n, LATENCY);
        check("b2b_result0", {15'd0, dut_res()}, {15'd0, ref_bcd(0)});
        check("b2b_ready0", {31'd0, in_ready}, 32'd1);
        $display("conv v=0 -> dig=%h ovf=%0b (back-to-back first)", dut_res() & 17'hFFFF, ovf);
        bin_in = 16'd9999;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accept_on_done", {31'd0, busy}, 32'd1);
        wait_done(1'b0, ref_bcd(0), n);
        check("b2b_latency1", n, LATENCY);
        check("b2b_result1", {15'd0, dut_res()}, {15'd0, ref_bcd(9999)});
        $display("conv v=9999 -> dig=%h ovf=%0b (back-to-back second)", dut_res() & 17'hFFFF, ovf);
        @(negedge clk);

        // 3) overflow saturation, then the flag clears
        convert(10000, 1'b0);
        convert(65535, 1'b0);
        convert(42, 1'b0);

        // 4) noisy inputs during busy
        convert(5678, 1'b1);

        // 5) reset in mid-conversion
        bin_in   = 16'd4321;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_still_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {15'd0, dut_res()}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        reset    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < LATENCY + 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        $display("abort v=4321 -> dig=%h ovf=%0b done_pulses=%0d", dut_res() & 17'hFFFF, ovf, done_cnt);

        // 6) boundaries plus random values
        foreach (bounds[i]) convert(bounds[i], 1'b1);
        for (int i = 0; i < 800; i++) begin
            if (i % 2 == 0) convert(int'($urandom_range(0, 9999)), 1'b1);
            else            convert(int'($urandom_range(0, 65535)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
